// File: rtl/rb_window_ctrl.sv
// Purpose: sequences a KxK sliding window over an IMG_W x IMG_H raster fed column by column from row buffers.
// Latency: one cycle from accepting a pixel column to win_valid for the window that column completes.
// Backpressure: a held window (win_valid && !out_ready) drops pix_ready, freezing counters and window registers.
module rb_window_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic                       shift_en,
    output logic                       win_valid,
    input  logic                       out_ready,
    output logic [$clog2(IMG_W)-1:0]   col_cnt,
    output logic [$clog2(IMG_H)-1:0]   row_cnt,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   col_d;
    logic [RW-1:0]   row_d;
    logic            win_valid_d;

    logic            accept;
    logic            last_col;
    logic            last_pix;
    logic            in_win;

    // Handshake and position decode; a window is complete once the accepted
    // column sits at least K-1 pixels into both dimensions.
    always_comb begin
        pix_ready = (state_q == RUN) && (!win_valid || out_ready);
        accept    = pix_valid && pix_ready;
        shift_en  = accept;
        last_col  = (col_cnt == CW'(IMG_W - 1));
        last_pix  = last_col && (row_cnt == RW'(IMG_H - 1));
        in_win    = (col_cnt >= CW'(K - 1)) && (row_cnt >= RW'(K - 1));
        busy      = (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == DONE);
    end

    // Next-state, raster counters and window-valid tracking.
    always_comb begin
        state_d     = state_q;
        col_d       = col_cnt;
        row_d       = row_cnt;
        win_valid_d = win_valid;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    col_d       = '0;
                    row_d       = '0;
                    win_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    // accept implies the previous window (if any) is consumed,
                    // so the new valid simply replaces it with no bubble
                    win_valid_d = in_win;
                    if (last_pix) begin
                        state_d = DRAIN;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_cnt + RW'(1);
                    end else begin
                        col_d = col_cnt + CW'(1);
                    end
                end else if (out_ready) begin
                    win_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                // wait for the final window to be taken before signalling done
                if (!win_valid || out_ready) begin
                    state_d     = DONE;
                    win_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_cnt   <= '0;
            row_cnt   <= '0;
            win_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_cnt   <= col_d;
            row_cnt   <= row_d;
            win_valid <= win_valid_d;
        end
    end

endmodule

// File: tb/tb_rb_window_ctrl.sv
module tb_rb_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KK = 3;
    localparam int NWIN = (W - KK + 1) * (H - KK + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       pix_ready;
    logic       shift_en;
    logic       win_valid;
    logic       busy;
    logic       done;
    logic [2:0] col_cnt;
    logic [2:0] row_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    rb_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .shift_en  (shift_en),
        .win_valid (win_valid),
        .out_ready (out_ready),
        .col_cnt   (col_cnt),
        .row_cnt   (row_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model / scoreboard state
    bit         mon_en = 1'b0;
    bit         m_run  = 1'b0;
    bit         exp_wv = 1'b0;
    logic [2:0] m_r = 3'd0;
    logic [2:0] m_c = 3'd0;
    int         q[$];
    int         acc_cnt = 0;
    int         hs_cnt = 0;
    int         first_acc_cyc = 0;
    int         last_acc_cyc = 0;
    int         acc22_cyc = 0;
    int         first_hs_cyc = 0;
    int         last_hs_cyc = 0;

    // Scoreboard monitor: push window ids on accept, pop on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            bit acc;
            bit nxt_wv;
            int id;
            acc = pix_valid && pix_ready;
            n_cmp++;
            if (pix_ready !== (m_run && (!exp_wv || out_ready))) begin
                n_err++;
                $display("FAIL pix_ready cyc=%0d got %b exp %b", cyc, pix_ready, m_run && (!exp_wv || out_ready));
            end
            n_cmp++;
            if (win_valid !== exp_wv) begin
                n_err++;
                $display("FAIL win_valid cyc=%0d got %b exp %b", cyc, win_valid, exp_wv);
            end
            n_cmp++;
            if (shift_en !== acc) begin
                n_err++;
                $display("FAIL shift_en cyc=%0d got %b exp %b", cyc, shift_en, acc);
            end
            if (win_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL window_order cyc=%0d got handshake exp no window pending", cyc);
                end else begin
                    id = q.pop_front();
                    if (id !== hs_cnt) begin
                        n_err++;
                        $display("FAIL window_order cyc=%0d got id %0d exp %0d", cyc, id, hs_cnt);
                    end
                end
                if (hs_cnt == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_cnt++;
            end
            if (acc) begin
                n_cmp++;
                if ({row_cnt, col_cnt} !== {m_r, m_c}) begin
                    n_err++;
                    $display("FAIL counters cyc=%0d got r%0d c%0d exp r%0d c%0d", cyc, row_cnt, col_cnt, m_r, m_c);
                end
                if (acc_cnt == 0) first_acc_cyc = cyc;
                last_acc_cyc = cyc;
                acc_cnt++;
                if (m_r == KK - 1 && m_c == KK - 1) acc22_cyc = cyc;
                nxt_wv = (m_r >= KK - 1) && (m_c >= KK - 1);
                if (nxt_wv) q.push_back((m_r - (KK - 1)) * (W - KK + 1) + (m_c - (KK - 1)));
                if (m_c == W - 1) begin
                    m_c = 3'd0;
                    if (m_r == H - 1) begin
                        m_r   = 3'd0;
                        m_run = 1'b0;
                    end else begin
                        m_r = m_r + 3'd1;
                    end
                end else begin
                    m_c = m_c + 3'd1;
                end
            end else begin
                nxt_wv = out_ready ? 1'b0 : exp_wv;
            end
            exp_wv = nxt_wv;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        q.delete();
        exp_wv  = 1'b0;
        m_r     = 3'd0;
        m_c     = 3'd0;
        acc_cnt = 0;
        hs_cnt  = 0;
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_model();
        m_run = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (win_valid !== 1'b0) begin n_err++; $display("FAIL rst_win_valid got %b exp 0", win_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
        n_cmp++; if (col_cnt !== 3'd0) begin n_err++; $display("FAIL rst_col got %0d exp 0", col_cnt); end
        n_cmp++; if (row_cnt !== 3'd0) begin n_err++; $display("FAIL rst_row got %0d exp 0", row_cnt); end
        n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL rst_pix_ready got %b exp 0", pix_ready); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        m_run = 1'b0;
        tick();
        mon_en = 1'b1;
        pix_valid = 1'b1;
        out_ready = 1'b1;
        repeat (4) tick();
        n_cmp++; if (busy !== 1'b0 || col_cnt !== 3'd0) begin n_err++; $display("FAIL idle_ignore got busy=%b col=%0d exp busy=0 col=0", busy, col_cnt); end
    endtask

    task automatic test_stream();
        pix_valid = 1'b1;
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stream_timeout got done=%b exp 1", done); end
        n_cmp++; if (acc_cnt !== W * H) begin n_err++; $display("FAIL stream_accepts got %0d exp %0d", acc_cnt, W * H); end
        n_cmp++; if (hs_cnt !== NWIN) begin n_err++; $display("FAIL stream_windows got %0d exp %0d", hs_cnt, NWIN); end
        n_cmp++; if (last_acc_cyc - first_acc_cyc !== W * H - 1) begin n_err++; $display("FAIL stream_rate got %0d exp %0d", last_acc_cyc - first_acc_cyc, W * H - 1); end
        n_cmp++; if (first_hs_cyc !== acc22_cyc + 1) begin n_err++; $display("FAIL first_window got %0d exp %0d", first_hs_cyc, acc22_cyc + 1); end
        n_cmp++; if (cyc !== last_hs_cyc + 1) begin n_err++; $display("FAIL done_timing got %0d exp %0d", cyc, last_hs_cyc + 1); end
    endtask

    task automatic test_stall();
        logic [2:0] c;
        logic [2:0] r;
        int a;
        pix_valid = 1'b1;
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 50 && !win_valid; i++) @(negedge clk);
        tick();
        out_ready = 1'b0;
        c = col_cnt;
        r = row_cnt;
        a = acc_cnt;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (pix_ready !== 1'b0 || win_valid !== 1'b1 || col_cnt !== c || row_cnt !== r) begin
                n_err++;
                $display("FAIL stall_hold got rdy=%b wv=%b r%0d c%0d exp rdy=0 wv=1 r%0d c%0d", pix_ready, win_valid, row_cnt, col_cnt, r, c);
            end
        end
        n_cmp++; if (acc_cnt !== a) begin n_err++; $display("FAIL stall_accepts got %0d exp %0d", acc_cnt, a); end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL stall_windows got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
    endtask

    task automatic test_toggle();
        int sh0 = 0;
        int c0;
        pix_valid = 1'b0;
        out_ready = 1'b1;
        start_frame();
        c0 = cyc;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            pix_valid = ~pix_valid;
            @(negedge clk);
            if (!pix_valid && shift_en) sh0++;
        end
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL toggle_windows got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
        n_cmp++; if (cyc - c0 < 2 * W * H) begin n_err++; $display("FAIL toggle_cycles got %0d exp >= %0d", cyc - c0, 2 * W * H); end
        n_cmp++; if (sh0 !== 0) begin n_err++; $display("FAIL toggle_shift got %0d exp 0", sh0); end
        pix_valid = 1'b0;
    endtask

    task automatic test_drain();
        pix_valid = 1'b1;
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 200 && acc_cnt < W * H - 1; i++) tick();
        pix_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        n_cmp++; if (acc_cnt !== W * H) begin n_err++; $display("FAIL drain_last_accept got %0d exp %0d", acc_cnt, W * H); end
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || win_valid !== 1'b1 || col_cnt !== 3'd0 || row_cnt !== 3'd0) begin
                n_err++;
                $display("FAIL drain_hold got busy=%b done=%b wv=%b r%0d c%0d exp 1 0 1 r0 c0", busy, done, win_valid, row_cnt, col_cnt);
            end
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL drain_early_done got %b exp 0", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL drain_done got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
    endtask

    task automatic test_reset_midframe();
        pix_valid = 1'b1;
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < 100 && acc_cnt < 30; i++) tick();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || col_cnt !== 3'd0 || row_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL midrst_async got wv=%b busy=%b done=%b r%0d c%0d exp all 0", win_valid, busy, done, row_cnt, col_cnt);
        end
        clear_model();
        m_run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        repeat (5) tick();
        n_cmp++; if (win_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_quiet got wv=%b busy=%b exp 0 0", win_valid, busy); end
        start_frame();
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL midrst_frame got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
    endtask

    task automatic test_restart();
        pix_valid = 1'b1;
        out_ready = 1'b1;
        start_frame();
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || acc_cnt !== 11) begin n_err++; $display("FAIL run_start_ignored got busy=%b acc=%0d exp busy=1 acc=11", busy, acc_cnt); end
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL restart_first got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL done_hold got %b exp 1", done); end
        start_frame();
        n_cmp++;
        if (col_cnt !== 3'd0 || row_cnt !== 3'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL restart_counters got r%0d c%0d busy=%b done=%b exp r0 c0 1 0", row_cnt, col_cnt, busy, done);
        end
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        n_cmp++; if (done !== 1'b1 || hs_cnt !== NWIN) begin n_err++; $display("FAIL restart_second got done=%b n=%0d exp done=1 n=%0d", done, hs_cnt, NWIN); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_drain();
        test_reset_midframe();
        test_restart();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
